seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
//  Serial pattern transmitter: the driving end of the 1-bit inbits stream that
//  seq_detect_non_ov consumes. On a start request it shifts a PAT_W-bit pattern
//  out MSB first, one bit per clk, repeated N times with optional zero gaps.
//  Used as the stimulus source for the sequence detectors and in loopback tests.
// PARAMETERS
//  PAT_W  4  pattern width in bits (>=2)
//  CNT_W  4  width of repeat-count input
//  GAP_W  3  width of inter-copy gap-length input
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      request a transmission; sampled only in IDLE
//  pattern    in   PAT_W  pattern to send, MSB first; captured on start
//  repeats    in   CNT_W  number of copies; 0 treated as 1; captured on start
//  gap        in   GAP_W  zero bits inserted between copies; captured on start
//  outbits    out  1      serial data; connects to detector inbits
//  out_valid  out  1      outbits carries a pattern or gap bit this cycle
//  busy       out  1      transmission in progress (SEND, GAP, DONE)
//  done       out  1      one-cycle pulse after the final bit
// BEHAVIOUR
//  - Moore FSM; all outputs registered and decoded from state plus shadow regs.
//  - Reset (async, any time): state=IDLE; outbits=0, out_valid=0, busy=0,
//    done=0; shadow pattern, copy and gap counters cleared. No clock edge is needed.
//  - States: IDLE, SEND, GAP, DONE.
//  - IDLE: outputs 0. start=1 at edge k: capture pattern, repeats (0->1) and gap.
//    Go to SEND. The first bit pattern[PAT_W-1] appears after edge k
//    (latency 1 cycle). out_valid=1 and busy=1 from that cycle.
//  - SEND: bit index runs from PAT_W-1 down to 0, one per cycle. After bit 0:
//      copies remaining and gap>0  -> GAP
//      copies remaining and gap==0 -> SEND, next copy MSB the following cycle
//      last copy                   -> DONE
//  - GAP: outbits=0, out_valid=1, for exactly gap cycles, then SEND (next copy).
//  - DONE: one cycle. done=1, busy=1, out_valid=0, outbits=0. Then IDLE.
//  - Total out_valid cycles = R*PAT_W + (R-1)*gap, where R = max(repeats,1).
//    gap is ignored when R==1.
//  - start while not in IDLE (including DONE) is ignored. Input changes after
//    capture have no effect.
//  - start held high: back-to-back runs. After each DONE there is 1 IDLE cycle
//    in which start is sampled, then the next run begins.
//  - Counters must not wrap. A copy counter sized for 2^CNT_W-1 copies and a
//    gap counter sized for 2^GAP_W-1 cycles are both exact.
// TESTING
//  1 Reset asserted mid-cycle during SEND -> all outputs 0 immediately, before
//    the next edge. After release, IDLE with outputs 0.
//  2 pattern=1011, repeats=1, gap=0, 1-cycle start -> outbits 1,0,1,1 on 4
//    valid cycles. done=1 on cycle 5. busy high for cycles 1-5.
//  3 pattern=1011, repeats=3, gap=2 -> 1011 00 1011 00 1011: 16 valid cycles,
//    exactly one done pulse.
//  4 repeats=0, gap=7 -> identical to a single copy, no gap bits.
//  5 start re-pulsed with pattern=0110 while busy -> ignored, 1011 stream
//    intact. start held high -> runs repeat with DONE,IDLE between.
//  6 Loopback into seq_detect_non_ov with its target pattern, repeats=5,
//    gap=1 -> exactly 5 detect pulses. A reset after the 2nd bit aborts the
//    stream with no detect.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter.
// On a start request in IDLE, shifts a captured PAT_W-bit pattern out MSB
// first, one bit per clock, repeated max(repeats,1) times with `gap` zero bits
// between copies, then pulses `done` for one cycle. All outputs are registered
// and are decoded from the next state plus the shadow registers.

module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeats,
    input  logic [GAP_W-1:0] gap,
    output logic             outbits,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state_q,     state_d;
    logic [PAT_W-1:0] pat_q,       pat_d;       // captured pattern
    logic [CNT_W-1:0] copies_q,    copies_d;    // copies left, including the one in flight
    logic [GAP_W-1:0] gap_q,       gap_d;       // captured gap length
    logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;   // gap cycles left, including the current one
    logic [IDX_W-1:0] idx_q,       idx_d;       // index of the bit currently on outbits
    logic             outbits_q,   outbits_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic [IDX_W-1:0] idx_dec;
    assign idx_dec = idx_q - IDX_W'(1);

    // Next-state and next-output decode for the transmit FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        state_d     = state_q;
        pat_d       = pat_q;
        copies_d    = copies_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        idx_d       = idx_q;
        outbits_d   = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d       = pattern;
                    copies_d    = (repeats == '0) ? CNT_W'(1) : repeats;
                    gap_d       = gap;
                    idx_d       = IDX_MSB;
                    state_d     = ST_SEND;
                    outbits_d   = pattern[PAT_W-1];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            ST_SEND: begin
                busy_d = 1'b1;
                if (idx_q != '0) begin
                    // Next bit of the current copy.
                    idx_d       = idx_dec;
                    outbits_d   = pat_q[idx_dec];
                    out_valid_d = 1'b1;
                end else if (copies_q > CNT_W'(1)) begin
                    // Copy finished and more remain: gap first if one was asked for.
                    copies_d    = copies_q - CNT_W'(1);
                    out_valid_d = 1'b1;
                    if (gap_q != '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                    end else begin
                        idx_d     = IDX_MSB;
                        outbits_d = pat_q[PAT_W-1];
                    end
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            ST_GAP: begin
                busy_d      = 1'b1;
                out_valid_d = 1'b1;
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = ST_SEND;
                    idx_d     = IDX_MSB;
                    outbits_d = pat_q[PAT_W-1];
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here; the following IDLE
                // cycle is the one that samples it.
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, shadow and output registers; async reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            copies_q    <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            idx_q       <= '0;
            outbits_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the previous state, not from each other.
            state_q     <= state_d;
            pat_q       <= pat_d;
            copies_q    <= copies_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            idx_q       <= idx_d;
            outbits_q   <= outbits_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign outbits   = outbits_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: a queue-based model of the expected output stream
// checked every cycle, plus directed runs with hand-computed literal totals.

module tb_seq_pattern_gen;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeats;
    logic [GAP_W-1:0] gap;
    logic             outbits;
    logic             out_valid;
    logic             busy;
    logic             done;

    seq_pattern_gen #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pattern  (pattern),
        .repeats  (repeats),
        .gap      (gap),
        .outbits  (outbits),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: queue of per-cycle expected {outbits, out_valid, busy, done}.
    // An empty queue means the generator is idle and samples start.
    logic [3:0] exp_q[$];
    logic [3:0] cur = 4'b0000;
    int         r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            cur <= 4'b0000;
        end else begin
            if (exp_q.size() == 0 && start) begin
                r = (repeats == 0) ? 1 : int'(repeats);
                for (int c = 0; c < r; c++) begin
                    for (int b = PAT_W - 1; b >= 0; b--)
                        exp_q.push_back({pattern[b], 3'b110});
                    if (c < r - 1)
                        for (int g = 0; g < int'(gap); g++)
                            exp_q.push_back(4'b0110);
                end
                exp_q.push_back(4'b0011);   // DONE cycle
                exp_q.push_back(4'b0000);   // IDLE cycle after DONE
            end
            if (exp_q.size() != 0) cur <= exp_q.pop_front();
            else                   cur <= 4'b0000;
        end
    end

    // Compare DUT outputs to the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (en) check("model", {28'd0, outbits, out_valid, busy, done}, {28'd0, cur});
    end

    // Monitor: running totals, received bit history, and a non-overlapping
    // 1011 detector standing in for the loopback sequence detector.
    int          valid_cnt = 0;
    int          done_cnt  = 0;
    int          busy_cnt  = 0;
    int          det_cnt   = 0;
    int          det_fill  = 0;
    logic [3:0]  det_sh    = 4'b0000;
    logic [31:0] rec_bits  = 32'd0;
    logic        det_hit;

    assign det_hit = (det_fill >= 3) && ({det_sh[2:0], outbits} == 4'b1011);

    always @(negedge clk) begin
        if (reset) begin
            det_fill <= 0;
            det_sh   <= 4'b0000;
        end else begin
            if (out_valid) begin
                valid_cnt <= valid_cnt + 1;
                rec_bits  <= {rec_bits[30:0], outbits};
                det_sh    <= {det_sh[2:0], outbits};
                if (det_hit) begin
                    det_cnt  <= det_cnt + 1;
                    det_fill <= 0;
                end else begin
                    det_fill <= det_fill + 1;
                end
            end
            if (done) done_cnt <= done_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    int v0, d0, b0, k0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        v0 = valid_cnt;
        d0 = done_cnt;
        b0 = busy_cnt;
        k0 = det_cnt;
    endtask

    task automatic send(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] rp,
                        input logic [GAP_W-1:0] g);
        pattern = p;
        repeats = rp;
        gap     = g;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("done_timeout", {31'd0, n < 400}, 32'd1);
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        repeats = '0;
        gap     = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        en = 1'b1;
        check("reset_state", {28'd0, outbits, out_valid, busy, done}, 32'd0);
        tick();

        // Single copy: latency 1, 4 valid bits, done on cycle 5, busy 5 cycles.
        snap();
        send(4'b1011, 4'd1, 3'd0);
        check("first_bit", {29'd0, outbits, out_valid, busy}, 32'b111);
        wait_done();
        check("single_valid", valid_cnt - v0, 32'd4);
        check("single_done",  done_cnt - d0,  32'd1);
        check("single_busy",  busy_cnt - b0,  32'd5);
        check("single_bits",  {28'd0, rec_bits[3:0]}, 32'b1011);

        // Three copies with 2-bit gaps.
        snap();
        send(4'b1011, 4'd3, 3'd2);
        wait_done();
        check("rep3_valid", valid_cnt - v0, 32'd16);
        check("rep3_done",  done_cnt - d0,  32'd1);
        check("rep3_busy",  busy_cnt - b0,  32'd17);
        check("rep3_bits",  {16'd0, rec_bits[15:0]}, 32'b1011001011001011);

        // repeats=0 behaves as one copy; gap is ignored.
        snap();
        send(4'b1011, 4'd0, 3'd7);
        wait_done();
        check("rep0_valid", valid_cnt - v0, 32'd4);
        check("rep0_done",  done_cnt - d0,  32'd1);
        check("rep0_bits",  {28'd0, rec_bits[3:0]}, 32'b1011);

        // Largest counts: 15 copies, 7-cycle gaps, no counter wrap.
        snap();
        send(4'b1001, 4'd15, 3'd7);
        wait_done();
        check("max_valid", valid_cnt - v0, 32'd158);
        check("max_busy",  busy_cnt - b0,  32'd159);
        check("max_done",  done_cnt - d0,  32'd1);
        check("max_tail",  {21'd0, rec_bits[10:0]}, 32'b00000001001);

        // start re-pulsed with new inputs while busy is ignored.
        snap();
        send(4'b1011, 4'd1, 3'd0);
        pattern = 4'b0110;
        repeats = 4'd4;
        gap     = 3'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done();
        check("ignore_valid", valid_cnt - v0, 32'd4);
        check("ignore_done",  done_cnt - d0,  32'd1);
        check("ignore_bits",  {28'd0, rec_bits[3:0]}, 32'b1011);

        // start held high: run, DONE, IDLE, run again.
        snap();
        pattern = 4'b1011;
        repeats = 4'd1;
        gap     = 3'd0;
        start   = 1'b1;
        repeat (12) tick();
        start   = 1'b0;
        repeat (10) tick();
        check("held_valid", valid_cnt - v0, 32'd8);
        check("held_done",  done_cnt - d0,  32'd2);

        // Asynchronous reset in the middle of SEND clears outputs immediately.
        send(4'b1011, 4'd3, 3'd2);
        tick();
        #3 reset = 1'b1;
        #1 check("async_reset", {28'd0, outbits, out_valid, busy, done}, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        tick();
        check("idle_after_reset", {28'd0, outbits, out_valid, busy, done}, 32'd0);
        tick();

        // Loopback: five copies of the detector target with 1-bit gaps.
        snap();
        send(4'b1011, 4'd5, 3'd1);
        wait_done();
        check("loop_detects", det_cnt - k0,   32'd5);
        check("loop_valid",   valid_cnt - v0, 32'd24);

        // Reset after the second bit aborts the stream with no detection.
        snap();
        send(4'b1011, 4'd1, 3'd0);
        tick();
        @(negedge clk);
        #1 reset = 1'b1;
        tick();
        #2 reset = 1'b0;
        repeat (10) tick();
        check("abort_detects", det_cnt - k0,   32'd0);
        check("abort_valid",   valid_cnt - v0, 32'd2);
        check("abort_done",    done_cnt - d0,  32'd0);

        en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
